// File: rtl/simple_fifo_pkg.sv
// Shared helpers for the sync and async FWFT FIFOs:
// sizing functions and parameter legality checks.
package simple_fifo_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction

    function automatic int level_w(input int aw);
        return aw + 1;
    endfunction

    function automatic bit aw_ok(input int aw);
        return (aw >= 1) && (aw <= 12);
    endfunction

    function automatic bit afull_ok(input int aw, input int th);
        return (th >= 1) && (th <= depth_of(aw));
    endfunction

    function automatic bit aempty_ok(input int aw, input int th);
        return (th >= 0) && (th <= depth_of(aw) - 1);
    endfunction

endpackage

// File: rtl/simple_dpram_ar.sv
// One write port, asynchronous read port memory.
// Contents are never reset.
module simple_dpram_ar #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/simple_fifo_sync_lvl.sv
// Single-clock FWFT FIFO with occupancy level, almost flags,
// synchronous flush and sticky overflow/underflow flags.
module simple_fifo_sync_lvl
    import simple_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int AFULL_TH   = 2**ADDR_WIDTH - 2,
    parameter int AEMPTY_TH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_ena,
    input  logic [DATA_WIDTH-1:0] wr_dat,
    output logic                  wr_full,
    output logic                  wr_afull,
    input  logic                  rd_ena,
    output logic [DATA_WIDTH-1:0] rd_dat,
    output logic                  rd_empty,
    output logic                  rd_aempty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  ovf,
    output logic                  udf
);

    localparam int DEPTH = depth_of(ADDR_WIDTH);
    localparam int LW    = level_w(ADDR_WIDTH);

    localparam logic [LW-1:0] DEPTH_V  = LW'(DEPTH);
    localparam logic [LW-1:0] AFULL_V  = LW'(AFULL_TH);
    localparam logic [LW-1:0] AEMPTY_V = LW'(AEMPTY_TH);

    if (!aw_ok(ADDR_WIDTH)) begin : g_bad_aw
        $error("ADDR_WIDTH must be 1..12");
    end
    if (!afull_ok(ADDR_WIDTH, AFULL_TH)) begin : g_bad_af
        $error("AFULL_TH must be 1..DEPTH");
    end
    if (!aempty_ok(ADDR_WIDTH, AEMPTY_TH)) begin : g_bad_ae
        $error("AEMPTY_TH must be 0..DEPTH-1");
    end

    logic [LW-1:0] wrptr_q, wrptr_d;
    logic [LW-1:0] rdptr_q, rdptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic          wr_acc;
    logic          rd_acc;
    logic          mem_we;

    assign wr_full   = (level_q == DEPTH_V);
    assign rd_empty  = (level_q == '0);
    assign wr_afull  = (level_q >= AFULL_V);
    assign rd_aempty = (level_q <= AEMPTY_V);
    assign level     = level_q;
    assign ovf       = ovf_q;
    assign udf       = udf_q;

    assign wr_acc = wr_ena & ~wr_full;
    assign rd_acc = rd_ena & ~rd_empty;

    // rst and flush both suppress the memory write
    assign mem_we = wr_acc & ~flush & ~rst;

    always_comb begin
        wrptr_d = wrptr_q;
        rdptr_d = rdptr_q;
        level_d = level_q;
        ovf_d   = ovf_q | (wr_ena & wr_full);
        udf_d   = udf_q | (rd_ena & rd_empty);
        if (wr_acc) begin
            wrptr_d = wrptr_q + LW'(1);
        end
        if (rd_acc) begin
            rdptr_d = rdptr_q + LW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrptr_q <= '0;
            rdptr_q <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wrptr_q <= wrptr_d;
            rdptr_q <= rdptr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    simple_dpram_ar #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk    (clk),
        .we_i   (mem_we),
        .waddr_i(wrptr_q[ADDR_WIDTH-1:0]),
        .wdata_i(wr_dat),
        .raddr_i(rdptr_q[ADDR_WIDTH-1:0]),
        .rdata_o(rd_dat)
    );

endmodule

// File: tb/tb_simple_fifo_sync_lvl.sv
// Directed scoreboard bench for simple_fifo_sync_lvl
// (DEPTH=4, AFULL_TH=3, AEMPTY_TH=1).
module tb_simple_fifo_sync_lvl;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int DEPTH = 4;
    localparam int AF = 3;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          wr_ena;
    logic [DW-1:0] wr_dat;
    logic          wr_full;
    logic          wr_afull;
    logic          rd_ena;
    logic [DW-1:0] rd_dat;
    logic          rd_empty;
    logic          rd_aempty;
    logic [AW:0]   level;
    logic          ovf;
    logic          udf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DW-1:0] sb[$];
    logic          m_ovf;
    logic          m_udf;

    simple_fifo_sync_lvl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .AFULL_TH  (AF),
        .AEMPTY_TH (AE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_ena   (wr_ena),
        .wr_dat   (wr_dat),
        .wr_full  (wr_full),
        .wr_afull (wr_afull),
        .rd_ena   (rd_ena),
        .rd_dat   (rd_dat),
        .rd_empty (rd_empty),
        .rd_aempty(rd_aempty),
        .level    (level),
        .ovf      (ovf),
        .udf      (udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        int n;
        n = sb.size();
        chk("level", 32'(level), 32'(n));
        chk("rd_empty", 32'(rd_empty), 32'(n == 0));
        chk("wr_full", 32'(wr_full), 32'(n == DEPTH));
        chk("wr_afull", 32'(wr_afull), 32'(n >= AF));
        chk("rd_aempty", 32'(rd_aempty), 32'(n <= AE));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("udf", 32'(udf), 32'(m_udf));
        chk("level_le_depth", 32'(level <= 3'(DEPTH)), 32'd1);
        if (n != 0) begin
            chk("rd_dat_head", 32'(rd_dat), 32'(sb[0]));
        end
    endtask

    // One clock: drive inputs, update scoreboard from pre-edge state,
    // then check the post-edge state.
    task automatic cyc(input logic w, input logic [DW-1:0] d,
                       input logic r, input logic f);
        bit full;
        bit empty;
        logic [DW-1:0] exp;
        wr_ena = w;
        wr_dat = d;
        rd_ena = r;
        flush  = f;
        full   = (sb.size() == DEPTH);
        empty  = (sb.size() == 0);
        if (f) begin
            sb.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            if (r && !empty) begin
                exp = sb.pop_front();
                chk("rd_dat_pop", 32'(rd_dat), 32'(exp));
            end
            if (w && !full) sb.push_back(d);
            if (w && full) m_ovf = 1'b1;
            if (r && empty) m_udf = 1'b1;
        end
        @(posedge clk);
        #1;
        wr_ena = 1'b0;
        rd_ena = 1'b0;
        flush  = 1'b0;
        check_state();
    endtask

    initial begin
        rst    = 1'b1;
        flush  = 1'b0;
        wr_ena = 1'b0;
        rd_ena = 1'b0;
        wr_dat = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_state();

        cyc(0, 8'h00, 0, 0);

        cyc(1, 8'h11, 0, 0);
        chk("first_word", 32'(rd_dat), 32'h11);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        cyc(1, 8'h44, 0, 0);

        cyc(1, 8'h55, 0, 0);
        chk("ovf_set", 32'(ovf), 32'd1);
        cyc(1, 8'h66, 1, 0);
        chk("full_rw_head", 32'(rd_dat), 32'h22);
        chk("full_rw_level", 32'(level), 32'd3);

        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(0, 8'h00, 1, 0);
        cyc(1, 8'h77, 1, 0);
        chk("udf_set", 32'(udf), 32'd1);
        chk("empty_rw_head", 32'(rd_dat), 32'h77);

        cyc(0, 8'h00, 0, 1);
        cyc(1, 8'h80, 0, 0);
        cyc(1, 8'h81, 0, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 8'hA0 + 8'(i), 1, 0);
        end
        chk("stream_level", 32'(level), 32'd2);
        chk("stream_flags", 32'({ovf, udf}), 32'd0);

        cyc(1, 8'hB0, 0, 0);
        cyc(1, 8'hB1, 0, 0);
        cyc(1, 8'hB2, 0, 0);
        cyc(0, 8'h00, 1, 0);
        chk("pre_flush_level", 32'(level), 32'd3);
        cyc(1, 8'hBB, 0, 1);
        chk("flush_level", 32'(level), 32'd0);
        chk("flush_ovf", 32'(ovf), 32'd0);
        cyc(1, 8'h9A, 0, 0);
        chk("post_flush_word", 32'(rd_dat), 32'h9A);
        cyc(0, 8'h00, 1, 0);

        for (int i = 0; i < 6; i++) begin
            cyc(1, 8'hC0 + 8'(i), 0, 0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        check_state();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
